sdfa_weight_distributor: RTL and testbench



---
 rtl/sdfa_weight_distributor_if.sv | 24 ++
 rtl/sdfa_weight_distributor.sv | 156 +++++++++++++++
 tb/tb_sdfa_weight_distributor.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sdfa_weight_distributor_if.sv
// Weight-stream bundle between the source, the distributor and the NUM_BLK compute blocks.
// The slave modport is the distributor's view; the master modport is the surrounding system's view.
interface sdfa_weight_distributor_if #(
  parameter int NUM_BLK = 9,
  parameter int W_WIDTH = 8
);
  logic                       w_valid_in;
  logic [W_WIDTH-1:0]         weight_in;
  logic                       w_request_out;
  logic [NUM_BLK-1:0]         blk_w_valid;
  logic [NUM_BLK*W_WIDTH-1:0] blk_weight;
  logic [NUM_BLK-1:0]         blk_w_request;
  logic [NUM_BLK-1:0]         blk_w_set_done;

  modport master (
    output w_valid_in, weight_in, blk_w_request, blk_w_set_done,
    input  w_request_out, blk_w_valid, blk_weight
  );

  modport slave (
    input  w_valid_in, weight_in, blk_w_request, blk_w_set_done,
    output w_request_out, blk_w_valid, blk_weight
  );
endinterface

// File: rtl/sdfa_weight_distributor.sv
// Steers the incoming weight stream to the compute blocks, WORDS_PER_BLK words each in
// ascending order, skipping masked blocks and waiting for each block's set-done.
module sdfa_weight_distributor #(
  parameter int NUM_BLK       = 9,
  parameter int WORDS_PER_BLK = 114688,
  parameter int W_WIDTH       = 8,
  parameter int CNT_W         = 17,
  parameter int IDX_W         = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [NUM_BLK-1:0]       blk_mask,
  sdfa_weight_distributor_if.slave wif,
  output logic [IDX_W-1:0]         cur_blk,
  output logic                     busy,
  output logic                     all_done,
  output logic                     overrun_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD     = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_BLK-1:0]         mask_q, mask_d;
  logic [IDX_W-1:0]           cur_blk_q, cur_blk_d;
  logic                       busy_q, busy_d;
  logic                       all_done_q, all_done_d;
  logic                       overrun_q, overrun_d;
  logic [NUM_BLK-1:0]         valid_q, valid_d;
  logic [NUM_BLK*W_WIDTH-1:0] weight_q, weight_d;

  logic [NUM_BLK-1:0] sel;
  logic               accept;
  logic               cur_done;
  logic               last_word;
  logic               first_found, next_found;
  logic [IDX_W-1:0]   first_idx, next_idx;

  // Start takes priority, so a word presented alongside start is never forwarded.
  assign accept    = (state_q == S_LOAD) && wif.w_valid_in && !start;
  assign last_word = (cnt_q == CNT_W'(WORDS_PER_BLK - 1));
  assign cur_done  = |(sel & wif.blk_w_set_done);

  for (genvar gi = 0; gi < NUM_BLK; gi++) begin : g_blk
    assign sel[gi]     = (cur_blk_q == IDX_W'(gi));
    assign valid_d[gi] = accept && sel[gi];
    assign weight_d[gi*W_WIDTH +: W_WIDTH] = (accept && sel[gi]) ? wif.weight_in : '0;
  end

  assign wif.w_request_out = (state_q == S_LOAD) && |(sel & wif.blk_w_request);

  // Priority search from the top down leaves the lowest qualifying index.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_BLK - 1; i >= 0; i--) begin
      if (!blk_mask[i]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
      if (!mask_q[i] && (IDX_W'(i) > cur_blk_q)) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    cur_blk_d = cur_blk_q;
    overrun_d = overrun_q;
    if (start) begin
      mask_d    = blk_mask;
      cnt_d     = '0;
      overrun_d = 1'b0;
      if (first_found) begin
        cur_blk_d = first_idx;
        state_d   = S_LOAD;
      end else begin
        cur_blk_d = '0;
        state_d   = S_DONE;
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          if (wif.w_valid_in) begin
            if (last_word) begin
              cnt_d   = '0;
              state_d = S_WAIT_ACK;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_WAIT_ACK: begin
          if (cur_done) begin
            if (next_found) begin
              cur_blk_d = next_idx;
              state_d   = S_LOAD;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        default: ;
      endcase
      if (wif.w_valid_in && (state_q != S_LOAD)) begin
        overrun_d = 1'b1;
      end
    end
    busy_d     = (state_d == S_LOAD) || (state_d == S_WAIT_ACK);
    all_done_d = !start && (state_q == S_DONE) && (&(wif.blk_w_set_done | mask_q));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mask_q     <= '0;
      cur_blk_q  <= '0;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      overrun_q  <= 1'b0;
      valid_q    <= '0;
      weight_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      cur_blk_q  <= cur_blk_d;
      busy_q     <= busy_d;
      all_done_q <= all_done_d;
      overrun_q  <= overrun_d;
      valid_q    <= valid_d;
      weight_q   <= weight_d;
    end
  end

  assign wif.blk_w_valid = valid_q;
  assign wif.blk_weight  = weight_q;
  assign cur_blk         = cur_blk_q;
  assign busy            = busy_q;
  assign all_done        = all_done_q;
  assign overrun_err     = overrun_q;

endmodule

// File: tb/tb_sdfa_weight_distributor.sv
// Directed bench for sdfa_weight_distributor with 3 blocks of 4 byte-wide words.
module tb_sdfa_weight_distributor;
  localparam int NUM_BLK = 3;
  localparam int WPB     = 4;
  localparam int W_WIDTH = 8;
  localparam int CNT_W   = 3;
  localparam int IDX_W   = 2;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic [NUM_BLK-1:0] blk_mask;
  logic [IDX_W-1:0]   cur_blk;
  logic               busy;
  logic               all_done;
  logic               overrun_err;

  int n_cmp = 0;
  int n_err = 0;

  sdfa_weight_distributor_if #(.NUM_BLK(NUM_BLK), .W_WIDTH(W_WIDTH)) wif ();

  sdfa_weight_distributor #(
    .NUM_BLK(NUM_BLK), .WORDS_PER_BLK(WPB), .W_WIDTH(W_WIDTH),
    .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .blk_mask(blk_mask), .wif(wif),
    .cur_blk(cur_blk), .busy(busy), .all_done(all_done), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one word, then checks that only block b's slice carries it one cycle later.
  task automatic send_word(input int b, input logic [7:0] w);
    logic [31:0] ev, ed;
    ev = 32'd1 << b;
    ed = 32'(w) << (8 * b);
    wif.w_valid_in = 1'b1;
    wif.weight_in  = w;
    tick();
    chk($sformatf("valid w%02h", w), 32'(wif.blk_w_valid), ev);
    chk($sformatf("data w%02h", w), 32'(wif.blk_weight), ed);
    $display("word %02h -> blk %0d valid=%b data=%06h", w, b, wif.blk_w_valid, wif.blk_weight);
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    blk_mask = '0;
    wif.w_valid_in = 1'b0;
    wif.weight_in = '0;
    wif.blk_w_request = 3'b111;
    wif.blk_w_set_done = '0;
    tick();
    tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst all_done", 32'(all_done), 32'd0);
    chk("rst overrun", 32'(overrun_err), 32'd0);
    chk("rst cur_blk", 32'(cur_blk), 32'd0);
    chk("rst valid", 32'(wif.blk_w_valid), 32'd0);
    chk("rst req", 32'(wif.w_request_out), 32'd0);
    rstn = 1'b1;
    tick();
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle req", 32'(wif.w_request_out), 32'd0);

    // Basic load, all blocks enabled
    blk_mask = 3'b000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1 cur_blk", 32'(cur_blk), 32'd0);
    chk("t1 busy", 32'(busy), 32'd1);
    chk("t1 req", 32'(wif.w_request_out), 32'd1);
    for (int b = 0; b < NUM_BLK; b++) begin
      for (int k = 0; k < WPB; k++) send_word(b, 8'(1 + b * WPB + k));
      wif.w_valid_in = 1'b0;
      tick();
      chk($sformatf("t1 wait valid b%0d", b), 32'(wif.blk_w_valid), 32'd0);
      chk($sformatf("t1 wait cur b%0d", b), 32'(cur_blk), 32'(b));
      wif.blk_w_set_done[b] = 1'b1;
      tick();
      if (b < NUM_BLK - 1) chk($sformatf("t1 next cur b%0d", b), 32'(cur_blk), 32'(b + 1));
    end
    chk("t1 busy done", 32'(busy), 32'd0);
    chk("t1 all_done early", 32'(all_done), 32'd0);
    tick();
    chk("t1 all_done", 32'(all_done), 32'd1);
    chk("t1 overrun", 32'(overrun_err), 32'd0);
    chk("t1 done req", 32'(wif.w_request_out), 32'd0);

    // Block 1 masked
    wif.blk_w_set_done = '0;
    blk_mask = 3'b010;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2 cur_blk", 32'(cur_blk), 32'd0);
    chk("t2 all_done clr", 32'(all_done), 32'd0);
    for (int k = 0; k < WPB; k++) send_word(0, 8'(1 + k));
    wif.w_valid_in = 1'b0;
    wif.blk_w_set_done[0] = 1'b1;
    tick();
    tick();
    chk("t2 skip to 2", 32'(cur_blk), 32'd2);
    for (int k = 0; k < WPB; k++) send_word(2, 8'(5 + k));
    wif.w_valid_in = 1'b0;
    wif.blk_w_set_done[2] = 1'b1;
    tick();
    tick();
    chk("t2 busy", 32'(busy), 32'd0);
    tick();
    chk("t2 all_done", 32'(all_done), 32'd1);

    // Handshake stall: word 5 arrives before block 0 acknowledges
    wif.blk_w_set_done = '0;
    blk_mask = 3'b000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < WPB; k++) send_word(0, 8'(8'h11 + k));
    wif.weight_in = 8'h15;
    tick();
    wif.w_valid_in = 1'b0;
    chk("t3 drop valid", 32'(wif.blk_w_valid), 32'd0);
    chk("t3 overrun", 32'(overrun_err), 32'd1);
    chk("t3 busy", 32'(busy), 32'd1);
    tick();
    chk("t3 stall cur", 32'(cur_blk), 32'd0);
    wif.blk_w_set_done[0] = 1'b1;
    tick();
    chk("t3 ack cur", 32'(cur_blk), 32'd1);

    // Request mux follows block 1's request combinationally
    wif.blk_w_request = 3'b101;
    #1;
    chk("t4 req 101", 32'(wif.w_request_out), 32'd0);
    wif.blk_w_request = 3'b010;
    #1;
    chk("t4 req 010", 32'(wif.w_request_out), 32'd1);
    wif.blk_w_request = 3'b111;

    // Restart two words into block 1, with a word presented on the start cycle
    send_word(1, 8'h21);
    send_word(1, 8'h22);
    blk_mask = 3'b000;
    start = 1'b1;
    wif.weight_in = 8'h99;
    tick();
    start = 1'b0;
    wif.w_valid_in = 1'b0;
    wif.blk_w_set_done = '0;
    chk("t5 no fwd", 32'(wif.blk_w_valid), 32'd0);
    chk("t5 cur_blk", 32'(cur_blk), 32'd0);
    chk("t5 overrun clr", 32'(overrun_err), 32'd0);
    chk("t5 busy", 32'(busy), 32'd1);
    for (int k = 0; k < WPB; k++) send_word(0, 8'(8'h31 + k));
    wif.w_valid_in = 1'b0;
    tick();
    chk("t5 wait cur", 32'(cur_blk), 32'd0);

    // Asynchronous reset mid-LOAD
    wif.blk_w_set_done[0] = 1'b1;
    tick();
    wif.blk_w_set_done = '0;
    send_word(1, 8'h41);
    wif.w_valid_in = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("t6 valid", 32'(wif.blk_w_valid), 32'd0);
    chk("t6 data", 32'(wif.blk_weight), 32'd0);
    chk("t6 cur_blk", 32'(cur_blk), 32'd0);
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 req", 32'(wif.w_request_out), 32'd0);
    #2;
    rstn = 1'b1;
    tick();
    tick();
    chk("t6 idle busy", 32'(busy), 32'd0);
    chk("t6 idle req", 32'(wif.w_request_out), 32'd0);

    // Every block masked: straight to DONE
    blk_mask = 3'b111;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t7 busy", 32'(busy), 32'd0);
    chk("t7 all_done early", 32'(all_done), 32'd0);
    tick();
    chk("t7 all_done", 32'(all_done), 32'd1);
    chk("t7 valid", 32'(wif.blk_w_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
